// File: rtl/pixel_stream_fifo_pkg.sv
// Shared packet geometry and helpers for the pixel packet buffer.
// Packet field order is {x, y, colour}, matching the i2c_slave read-out.
package pixel_stream_fifo_pkg;

  localparam int unsigned PIX_COORD_W  = 8;
  localparam int unsigned PIX_COLOUR_W = 3;

  // {push accepted, pop effective}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int unsigned pkt_width(input int unsigned coord_w,
                                            input int unsigned colour_w);
    return 2 * coord_w + colour_w;
  endfunction

endpackage

// File: rtl/pixel_fifo_mem.sv
// Register-file storage for the pixel FIFO: one synchronous write port,
// one asynchronous read port.
module pixel_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 19
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pixel_stream_fifo.sv
// Pixel packet buffer between packet_generator and i2c_slave, with duplicate
// suppression, saturating drop/dup counters, high-water mark and flush.
module pixel_stream_fifo
  import pixel_stream_fifo_pkg::*;
#(
  parameter int unsigned COORD_W  = PIX_COORD_W,
  parameter int unsigned COLOUR_W = PIX_COLOUR_W,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DEDUP    = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push_valid,
  input  logic [COORD_W-1:0]       push_x,
  input  logic [COORD_W-1:0]       push_y,
  input  logic [COLOUR_W-1:0]      push_colour,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [COORD_W-1:0]       head_x,
  output logic [COORD_W-1:0]       head_y,
  output logic [COLOUR_W-1:0]      head_colour,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   high_water,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         dup_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned PW = pkt_width(COORD_W, COLOUR_W);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_LVL  = LW'(1);

  logic [PW-1:0]    pkt_in, rd_data;
  logic [PW-1:0]    head_q, head_d, last_q, last_d;
  logic             last_vld_q, last_vld_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [LW-1:0]    level_q, level_d, hw_q, hw_d;
  logic [CNT_W-1:0] drop_q, drop_d, dup_q, dup_d;
  logic             empty, full, pop_eff, is_dup, push_acc, push_drop;
  fifo_op_e         op;

  assign pkt_in  = {push_x, push_y, push_colour};
  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LVL);
  assign rd_next = rd_ptr_q + 1'b1;

  assign pop_eff   = pop && !empty;
  assign is_dup    = (DEDUP != 0) && last_vld_q && (pkt_in == last_q);
  assign push_acc  = push_valid && !is_dup && (!full || pop_eff);
  assign push_drop = push_valid && !is_dup && full && !pop_eff;
  assign op        = fifo_op_e'({push_acc, pop_eff});

  // Storage read is always the entry behind the head, so head_q can be
  // refilled on a pop without any path from pop to the head outputs.
  pixel_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (PW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push_acc && !clear),
    .waddr_i (wr_ptr_q),
    .wdata_i (pkt_in),
    .raddr_i (rd_next),
    .rdata_o (rd_data)
  );

  always_comb begin
    head_d     = head_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_d     = drop_q;
    dup_d      = dup_q;

    // With a single stored entry the new head has not been written yet,
    // so it is taken straight from the push inputs.
    unique case (op)
      OP_PUSH: begin
        level_d = level_q + 1'b1;
        if (empty) head_d = pkt_in;
      end
      OP_POP: begin
        level_d = level_q - 1'b1;
        if (level_q != ONE_LVL) head_d = rd_data;
      end
      OP_BOTH: begin
        head_d = (level_q == ONE_LVL) ? pkt_in : rd_data;
      end
      default: ;
    endcase

    if (push_acc) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      last_d     = pkt_in;
      last_vld_d = 1'b1;
    end
    if (pop_eff) rd_ptr_d = rd_next;
    if (push_drop && (drop_q != '1)) drop_d = drop_q + 1'b1;
    if (is_dup && push_valid && (dup_q != '1)) dup_d = dup_q + 1'b1;

    hw_d = (level_d > hw_q) ? level_d : hw_q;

    if (clear) begin
      head_d     = '0;
      last_d     = '0;
      last_vld_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      hw_d       = '0;
      drop_d     = '0;
      dup_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      hw_q       <= '0;
      drop_q     <= '0;
      dup_q      <= '0;
    end else begin
      head_q     <= head_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      hw_q       <= hw_d;
      drop_q     <= drop_d;
      dup_q      <= dup_d;
    end
  end

  assign head_valid  = !empty;
  assign head_x      = head_q[PW-1 -: COORD_W];
  assign head_y      = head_q[COLOUR_W +: COORD_W];
  assign head_colour = head_q[COLOUR_W-1:0];
  assign level       = level_q;
  assign high_water  = hw_q;
  assign drop_cnt    = drop_q;
  assign dup_cnt     = dup_q;

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Directed bench for pixel_stream_fifo (DEPTH=16, DEDUP=1, CNT_W=8).
module tb_pixel_stream_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       push_valid = 1'b0;
  logic [7:0] push_x = '0;
  logic [7:0] push_y = '0;
  logic [2:0] push_colour = '0;
  logic       pop = 1'b0;
  logic       head_valid;
  logic [7:0] head_x, head_y;
  logic [2:0] head_colour;
  logic [4:0] level, high_water;
  logic [7:0] drop_cnt, dup_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pixel_stream_fifo #(
    .COORD_W  (8),
    .COLOUR_W (3),
    .DEPTH    (16),
    .DEDUP    (1),
    .CNT_W    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .push_valid  (push_valid),
    .push_x      (push_x),
    .push_y      (push_y),
    .push_colour (push_colour),
    .pop         (pop),
    .head_valid  (head_valid),
    .head_x      (head_x),
    .head_y      (head_y),
    .head_colour (head_colour),
    .level       (level),
    .high_water  (high_water),
    .drop_cnt    (drop_cnt),
    .dup_cnt     (dup_cnt)
  );

  typedef struct {
    bit clr; bit pv; int x; int y; int c; bit pp;
    bit hv; int hx; int hy; int hc; int lvl; int hw; int drop; int dup;
  } vec_t;

  vec_t vec [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit hv, input int hx, input int hy,
                         input int hc, input int lvl, input int hw, input int drp,
                         input int dp);
    chk({tag, ".head_valid"}, 32'(head_valid), 32'(hv));
    chk({tag, ".head_x"}, 32'(head_x), 32'(hx));
    chk({tag, ".head_y"}, 32'(head_y), 32'(hy));
    chk({tag, ".head_colour"}, 32'(head_colour), 32'(hc));
    chk({tag, ".level"}, 32'(level), 32'(lvl));
    chk({tag, ".high_water"}, 32'(high_water), 32'(hw));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(drp));
    chk({tag, ".dup_cnt"}, 32'(dup_cnt), 32'(dp));
  endtask

  // Inputs are applied, one rising edge taken, outputs sampled 1ns later.
  task automatic step(input bit clr, input bit pv, input int x, input int y,
                      input int c, input bit pp);
    clear       = clr;
    push_valid  = pv;
    push_x      = 8'(x);
    push_y      = 8'(y);
    push_colour = 3'(c);
    pop         = pp;
    @(posedge clk);
    #1;
    clear      = 1'b0;
    push_valid = 1'b0;
    pop        = 1'b0;
  endtask

  initial begin
    //          clr pv  x   y   c  pop  hv  hx  hy  hc lvl hw drop dup
    vec[0]  = '{0, 0,  0,  0,  0, 0,   0,  0,  0,  0, 0,  0, 0, 0};
    vec[1]  = '{0, 1, 10, 20,  3, 0,   1, 10, 20,  3, 1,  1, 0, 0};
    vec[2]  = '{0, 0,  0,  0,  0, 1,   0, 10, 20,  3, 0,  1, 0, 0};
    vec[3]  = '{0, 1,  5,  5,  1, 0,   1,  5,  5,  1, 1,  1, 0, 0};
    vec[4]  = '{0, 1,  5,  5,  1, 0,   1,  5,  5,  1, 1,  1, 0, 1};
    vec[5]  = '{0, 1,  5,  5,  1, 0,   1,  5,  5,  1, 1,  1, 0, 2};
    vec[6]  = '{0, 0,  0,  0,  0, 1,   0,  5,  5,  1, 0,  1, 0, 2};
    vec[7]  = '{0, 1,  5,  5,  1, 0,   0,  5,  5,  1, 0,  1, 0, 3};
    vec[8]  = '{0, 0,  0,  0,  0, 1,   0,  5,  5,  1, 0,  1, 0, 3};
    vec[9]  = '{0, 1,  7,  8,  2, 1,   1,  7,  8,  2, 1,  1, 0, 3};
    vec[10] = '{0, 1,  9,  9,  4, 0,   1,  7,  8,  2, 2,  2, 0, 3};
    vec[11] = '{0, 1,  9,  9,  4, 1,   1,  9,  9,  4, 1,  2, 0, 4};
    vec[12] = '{1, 1,  1,  2,  3, 1,   0,  0,  0,  0, 0,  0, 0, 0};
    vec[13] = '{0, 1,  9,  9,  4, 0,   1,  9,  9,  4, 1,  1, 0, 0};
    vec[14] = '{1, 0,  0,  0,  0, 0,   0,  0,  0,  0, 0,  0, 0, 0};

    #12 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      step(vec[i].clr, vec[i].pv, vec[i].x, vec[i].y, vec[i].c, vec[i].pp);
      chk_all($sformatf("v%0d", i), vec[i].hv, vec[i].hx, vec[i].hy, vec[i].hc,
              vec[i].lvl, vec[i].hw, vec[i].drop, vec[i].dup);
    end

    // Overfill: 18 distinct pushes into 16 entries.
    for (int i = 0; i < 18; i++) step(0, 1, i, 100 + i, i % 8, 0);
    chk_all("overfill", 1, 0, 100, 0, 16, 16, 2, 0);

    // Push+pop while full, then drain across the pointer wrap.
    step(0, 1, 50, 150, 5, 1);
    chk_all("full_pushpop", 1, 1, 101, 1, 16, 16, 2, 0);
    for (int k = 0; k < 16; k++) begin
      if (k < 15) begin
        chk($sformatf("drain%0d.x", k), 32'(head_x), 32'(k + 1));
        chk($sformatf("drain%0d.y", k), 32'(head_y), 32'(101 + k));
        chk($sformatf("drain%0d.c", k), 32'(head_colour), 32'((k + 1) % 8));
      end else begin
        chk("drain15.x", 32'(head_x), 32'd50);
        chk("drain15.y", 32'(head_y), 32'd150);
        chk("drain15.c", 32'(head_colour), 32'd5);
      end
      step(0, 0, 0, 0, 0, 1);
    end
    chk_all("drained", 0, 50, 150, 5, 0, 16, 2, 0);

    // Drop counter saturation.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, i, i, 0, 0);
    for (int i = 0; i < 300; i++) step(0, 1, 200, i % 256, (i / 256) + 1, 0);
    chk_all("drop_sat", 1, 0, 0, 0, 16, 16, 255, 0);

    // Asynchronous reset mid-burst.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 30 + i, 60, 2, 0);
    chk_all("fill7", 1, 30, 60, 2, 7, 7, 0, 0);
    push_valid = 1'b1; push_x = 8'd77; push_y = 8'd77; push_colour = 3'd7;
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    rst = 1'b0;
    chk_all("rst_held", 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 36, 60, 2, 0);
    chk_all("post_rst_push", 1, 36, 60, 2, 1, 1, 0, 0);
    step(0, 1, 36, 60, 2, 0);
    chk_all("post_rst_dup", 1, 36, 60, 2, 1, 1, 0, 1);

    // Clear with a same-cycle push at level 7.
    for (int i = 0; i < 6; i++) step(0, 1, 40 + i, 60, 2, 0);
    chk_all("refill7", 1, 36, 60, 2, 7, 7, 0, 1);
    step(1, 1, 45, 60, 2, 1);
    chk_all("clear_push", 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 45, 60, 2, 0);
    chk_all("post_clear_push", 1, 45, 60, 2, 1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
